// File: rtl/vga_timing_pkg.sv
// Shared constants, FSM state type and sync-polarity encodings for the VGA raster timing generator.
package vga_timing_pkg;

    // Standard 640x480@60 raster
    localparam int unsigned STD_H_VISIBLE_AREA = 640;
    localparam int unsigned STD_H_FRONT_PORCH  = 16;
    localparam int unsigned STD_H_SYNC_PULSE   = 96;
    localparam int unsigned STD_H_BACK_PORCH   = 48;
    localparam int unsigned STD_V_VISIBLE_AREA = 480;
    localparam int unsigned STD_V_FRONT_PORCH  = 10;
    localparam int unsigned STD_V_SYNC_PULSE   = 2;
    localparam int unsigned STD_V_BACK_PORCH   = 33;
    localparam int unsigned STD_H_TOTAL = STD_H_VISIBLE_AREA + STD_H_FRONT_PORCH
                                        + STD_H_SYNC_PULSE + STD_H_BACK_PORCH;
    localparam int unsigned STD_V_TOTAL = STD_V_VISIBLE_AREA + STD_V_FRONT_PORCH
                                        + STD_V_SYNC_PULSE + STD_V_BACK_PORCH;

    // Values for the *_SYNC_ACTIVE_LOW parameters
    localparam bit SYNC_POL_HIGH = 1'b0;
    localparam bit SYNC_POL_LOW  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } timing_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on advance, wraps to 0, and flags the wrapping step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = STD_H_TOTAL,
    parameter int unsigned WIDTH = 10
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             advance,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = advance && (count == WIDTH'(TOTAL - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel divider and frame-aligned enable.
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit o_Frame_Count output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE_AREA    = STD_H_VISIBLE_AREA,
    parameter int unsigned H_FRONT_PORCH     = STD_H_FRONT_PORCH,
    parameter int unsigned H_SYNC_PULSE      = STD_H_SYNC_PULSE,
    parameter int unsigned H_BACK_PORCH      = STD_H_BACK_PORCH,
    parameter int unsigned V_VISIBLE_AREA    = STD_V_VISIBLE_AREA,
    parameter int unsigned V_FRONT_PORCH     = STD_V_FRONT_PORCH,
    parameter int unsigned V_SYNC_PULSE      = STD_V_SYNC_PULSE,
    parameter int unsigned V_BACK_PORCH      = STD_V_BACK_PORCH,
    parameter bit          H_SYNC_ACTIVE_LOW = SYNC_POL_HIGH,
    parameter bit          V_SYNC_ACTIVE_LOW = SYNC_POL_HIGH,
    parameter int unsigned PIXEL_DIV         = 1,
    parameter int unsigned COUNTER_WIDTH     = 10
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Enable,
    output logic                     o_Running,
    output logic                     o_Pixel_En,
    output logic [COUNTER_WIDTH-1:0] o_H_Counter,
    output logic [COUNTER_WIDTH-1:0] o_V_Counter,
    output logic                     o_Visible,
    output logic                     o_VGA_HSync,
    output logic                     o_VGA_VSync,
    output logic                     o_Line_Start,
    output logic                     o_Frame_Start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]              o_Frame_Count
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int unsigned V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int unsigned H_SYNC_START = H_VISIBLE_AREA + H_FRONT_PORCH;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_PULSE;
    localparam int unsigned V_SYNC_START = V_VISIBLE_AREA + V_FRONT_PORCH;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_PULSE;
    localparam int unsigned DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
    localparam logic H_SYNC_OFF = H_SYNC_ACTIVE_LOW;
    localparam logic H_SYNC_ON  = !H_SYNC_ACTIVE_LOW;
    localparam logic V_SYNC_OFF = V_SYNC_ACTIVE_LOW;
    localparam logic V_SYNC_ON  = !V_SYNC_ACTIVE_LOW;

    if (PIXEL_DIV < 1) begin : g_bad_pixel_div
        $error("vga_timing_gen: PIXEL_DIV must be at least 1");
    end
    if ((((H_TOTAL - 1) >> COUNTER_WIDTH) != 0) || (((V_TOTAL - 1) >> COUNTER_WIDTH) != 0)) begin : g_bad_width
        $error("vga_timing_gen: COUNTER_WIDTH too small for H_TOTAL-1 or V_TOTAL-1");
    end

    timing_state_t            state, state_d;
    logic [DIV_W-1:0]         div_cnt;
    logic [COUNTER_WIDTH-1:0] h_cnt, v_cnt;
    logic running, pix_last, h_adv, h_wrap, v_wrap, cnt_clear;
    logic pix_en_d, line_start_d, frame_start_d, visible_d, hsync_on_d, vsync_on_d;

    assign running   = (state != IDLE);
    assign pix_last  = (div_cnt == DIV_W'(PIXEL_DIV - 1));
    assign h_adv     = running && pix_last;
    assign cnt_clear = (state_d == IDLE);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Stopping is only allowed once the last pixel of the frame completes
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (i_Enable) state_d = RUN;
            RUN:     if (!i_Enable) state_d = DRAIN;
            DRAIN: begin
                if (i_Enable) begin
                    state_d = RUN;
                end else if (v_wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst || cnt_clear) begin
            div_cnt <= '0;
        end else if (running) begin
            div_cnt <= pix_last ? '0 : div_cnt + DIV_W'(1);
        end
    end

    vga_axis_counter #(.TOTAL(H_TOTAL), .WIDTH(COUNTER_WIDTH)) u_h_counter (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .advance (h_adv),
        .clear   (cnt_clear),
        .count   (h_cnt),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .WIDTH(COUNTER_WIDTH)) u_v_counter (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .advance (h_wrap),
        .clear   (cnt_clear),
        .count   (v_cnt),
        .wrap    (v_wrap)
    );

    always_comb begin
        pix_en_d      = running && (div_cnt == '0);
        line_start_d  = pix_en_d && (h_cnt == '0);
        frame_start_d = line_start_d && (v_cnt == '0);
        visible_d     = running && (32'(h_cnt) < H_VISIBLE_AREA) && (32'(v_cnt) < V_VISIBLE_AREA);
        hsync_on_d    = running && (32'(h_cnt) >= H_SYNC_START) && (32'(h_cnt) < H_SYNC_END);
        vsync_on_d    = running && (32'(v_cnt) >= V_SYNC_START) && (32'(v_cnt) < V_SYNC_END);
    end

    // Every output is taken from the same pre-edge counter snapshot, so they stay aligned
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Running     <= 1'b0;
            o_Pixel_En    <= 1'b0;
            o_H_Counter   <= '0;
            o_V_Counter   <= '0;
            o_Visible     <= 1'b0;
            o_VGA_HSync   <= H_SYNC_OFF;
            o_VGA_VSync   <= V_SYNC_OFF;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Running     <= running;
            o_Pixel_En    <= pix_en_d;
            o_H_Counter   <= h_cnt;
            o_V_Counter   <= v_cnt;
            o_Visible     <= visible_d;
            o_VGA_HSync   <= hsync_on_d ? H_SYNC_ON : H_SYNC_OFF;
            o_VGA_VSync   <= vsync_on_d ? V_SYNC_ON : V_SYNC_OFF;
            o_Line_Start  <= line_start_d;
            o_Frame_Start <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic first_frame_seen;

    // The first frame after leaving IDLE is not counted
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Frame_Count    <= 16'd0;
            first_frame_seen <= 1'b0;
        end else if (state == IDLE) begin
            first_frame_seen <= 1'b0;
        end else if (frame_start_d) begin
            if (first_frame_seen) begin
                o_Frame_Count <= o_Frame_Count + 16'd1;
            end
            first_frame_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations checked every cycle against a time-based raster model.
module tb_vga_timing_gen;

    localparam int ND = 4;
    localparam int unsigned C_HV  [ND] = '{640, 640, 4, 5};
    localparam int unsigned C_HFP [ND] = '{16, 16, 1, 2};
    localparam int unsigned C_HSP [ND] = '{96, 96, 2, 3};
    localparam int unsigned C_HBP [ND] = '{48, 48, 1, 2};
    localparam int unsigned C_VV  [ND] = '{480, 480, 3, 4};
    localparam int unsigned C_VFP [ND] = '{10, 10, 1, 1};
    localparam int unsigned C_VSP [ND] = '{2, 2, 1, 2};
    localparam int unsigned C_VBP [ND] = '{33, 33, 1, 1};
    localparam bit          C_HAL [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit          C_VAL [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam int unsigned C_PD  [ND] = '{1, 4, 1, 3};

    typedef struct packed {
        logic        running;
        logic        pix_en;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        vis;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst [ND];
    logic en  [ND];
    logic run_w [ND];
    logic pe_w  [ND];
    logic vis_w [ND];
    logic hs_w  [ND];
    logic vs_w  [ND];
    logic ls_w  [ND];
    logic fs_w  [ND];
    logic [9:0]  h_w  [ND];
    logic [9:0]  v_w  [ND];
    logic [15:0] fc_w [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        vga_timing_gen #(
            .H_VISIBLE_AREA    (C_HV[g]),
            .H_FRONT_PORCH     (C_HFP[g]),
            .H_SYNC_PULSE      (C_HSP[g]),
            .H_BACK_PORCH      (C_HBP[g]),
            .V_VISIBLE_AREA    (C_VV[g]),
            .V_FRONT_PORCH     (C_VFP[g]),
            .V_SYNC_PULSE      (C_VSP[g]),
            .V_BACK_PORCH      (C_VBP[g]),
            .H_SYNC_ACTIVE_LOW (C_HAL[g]),
            .V_SYNC_ACTIVE_LOW (C_VAL[g]),
            .PIXEL_DIV         (C_PD[g]),
            .COUNTER_WIDTH     (10)
        ) u_dut (
            .i_Clk         (clk),
            .i_Rst         (rst[g]),
            .i_Enable      (en[g]),
            .o_Running     (run_w[g]),
            .o_Pixel_En    (pe_w[g]),
            .o_H_Counter   (h_w[g]),
            .o_V_Counter   (v_w[g]),
            .o_Visible     (vis_w[g]),
            .o_VGA_HSync   (hs_w[g]),
            .o_VGA_VSync   (vs_w[g]),
            .o_Line_Start  (ls_w[g]),
            .o_Frame_Start (fs_w[g])
`ifdef VGA_TIMING_FRAME_CNT_EN
            ,
            .o_Frame_Count (fc_w[g])
`endif
        );
`ifndef VGA_TIMING_FRAME_CNT_EN
        assign fc_w[g] = 16'd0;
`endif
    end

    // Reference model: generator active flag plus elapsed clocks since it started
    bit          m_act  [ND];
    int unsigned m_t    [ND];
    bit          m_enp  [ND];
    int unsigned m_fc   [ND];
    bit          m_seen [ND];
    obs_t        exp_o  [ND];

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    function automatic obs_t idle_obs(int d);
        obs_t o = '0;
        o.hs = C_HAL[d];
        o.vs = C_VAL[d];
        o.fc = 16'(m_fc[d]);
        return o;
    endfunction

    function automatic obs_t active_obs(int d);
        obs_t o = '0;
        int unsigned ht, vt, p, hh, vv;
        ht = C_HV[d] + C_HFP[d] + C_HSP[d] + C_HBP[d];
        vt = C_VV[d] + C_VFP[d] + C_VSP[d] + C_VBP[d];
        p  = m_t[d] / C_PD[d];
        hh = p % ht;
        vv = (p / ht) % vt;
        o.running = 1'b1;
        o.pix_en  = ((m_t[d] % C_PD[d]) == 0);
        o.h       = 10'(hh);
        o.v       = 10'(vv);
        o.vis     = (hh < C_HV[d]) && (vv < C_VV[d]);
        o.hs      = ((hh >= C_HV[d] + C_HFP[d]) && (hh < C_HV[d] + C_HFP[d] + C_HSP[d])) ? !C_HAL[d] : C_HAL[d];
        o.vs      = ((vv >= C_VV[d] + C_VFP[d]) && (vv < C_VV[d] + C_VFP[d] + C_VSP[d])) ? !C_VAL[d] : C_VAL[d];
        o.ls      = o.pix_en && (hh == 0);
        o.fs      = o.ls && (vv == 0);
        return o;
    endfunction

    // Expected outputs after the coming edge, then advance the model across it
    task automatic model_edge(int d);
        int unsigned frame_len;
        frame_len = (C_HV[d] + C_HFP[d] + C_HSP[d] + C_HBP[d])
                  * (C_VV[d] + C_VFP[d] + C_VSP[d] + C_VBP[d]) * C_PD[d];
        if (rst[d]) begin
            m_act[d]  = 1'b0;
            m_fc[d]   = 0;
            m_seen[d] = 1'b0;
            exp_o[d]  = idle_obs(d);
        end else if (!m_act[d]) begin
            m_seen[d] = 1'b0;
            exp_o[d]  = idle_obs(d);
            if (en[d]) begin
                m_act[d] = 1'b1;
                m_t[d]   = 0;
            end
        end else begin
            exp_o[d] = active_obs(d);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (exp_o[d].fs) begin
                if (m_seen[d]) m_fc[d] = (m_fc[d] + 32'd1) % 65536;
                m_seen[d] = 1'b1;
            end
`endif
            exp_o[d].fc = 16'(m_fc[d]);
            if (((m_t[d] % frame_len) == frame_len - 1) && !en[d] && !m_enp[d]) begin
                m_act[d] = 1'b0;
            end else begin
                m_t[d] = m_t[d] + 1;
            end
        end
        m_enp[d] = en[d];
    endtask

    function automatic obs_t get_obs(int d);
        obs_t o;
        o.running = run_w[d];
        o.pix_en  = pe_w[d];
        o.h       = h_w[d];
        o.v       = v_w[d];
        o.vis     = vis_w[d];
        o.hs      = hs_w[d];
        o.vs      = vs_w[d];
        o.ls      = ls_w[d];
        o.fs      = fs_w[d];
        o.fc      = fc_w[d];
        return o;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        for (int d = 0; d < ND; d++) model_edge(d);
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("outs%0d", d), {21'b0, get_obs(d)}, {21'b0, exp_o[d]});
        end
    endtask

    initial begin
        bit found;
        int n;
        int gap;
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1;
            en[d]  = 1'b0;
        end
        repeat (3) tick();
        chk("rst_hs_a", 64'(hs_w[0]), 64'd0);
        chk("rst_hs_c", 64'(hs_w[2]), 64'd1);
        chk("rst_vs_c", 64'(vs_w[2]), 64'd1);
        chk("rst_run_a", 64'(run_w[0]), 64'd0);

        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b0;
            en[d]  = 1'b1;
        end
        tick();
        chk("start_lat_run_a", 64'(run_w[0]), 64'd0);
        tick();
        chk("start_run_a", 64'(run_w[0]), 64'd1);
        chk("start_fs_a", 64'(fs_w[0]), 64'd1);
        chk("start_ls_a", 64'(ls_w[0]), 64'd1);
        chk("start_pe_a", 64'(pe_w[0]), 64'd1);
        chk("start_vis_a", 64'(vis_w[0]), 64'd1);
        chk("start_hv_a", 64'({h_w[0], v_w[0]}), 64'd0);

        repeat (144) tick();
        chk("tiny_fs_c", 64'(fs_w[2]), 64'd1);
        chk("tiny_hv_c", 64'({h_w[2], v_w[2]}), 64'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("tiny_fc4_c", 64'(fc_w[2]), 64'd3);
`endif
        repeat (5) tick();
        chk("tiny_hs_h5_c", 64'(hs_w[2]), 64'd0);
        repeat (2) tick();
        chk("tiny_hs_h7_c", 64'(hs_w[2]), 64'd1);
        repeat (25) tick();
        chk("tiny_v4_c", 64'(v_w[2]), 64'd4);
        chk("tiny_vs_v4_c", 64'(vs_w[2]), 64'd0);
        repeat (8) tick();
        chk("tiny_vs_v5_c", 64'(vs_w[2]), 64'd1);

        repeat (456) tick();
        chk("h640_a", 64'(h_w[0]), 64'd640);
        chk("vis_h640_a", 64'(vis_w[0]), 64'd0);
        repeat (16) tick();
        chk("hs_h656_a", 64'(hs_w[0]), 64'd1);
        repeat (95) tick();
        chk("hs_h751_a", 64'(hs_w[0]), 64'd1);
        tick();
        chk("hs_h752_a", 64'(hs_w[0]), 64'd0);
        repeat (48) tick();
        chk("line2_hv_a", 64'({h_w[0], v_w[0]}), {44'd0, 10'd0, 10'd1});
        chk("line2_ls_a", 64'(ls_w[0]), 64'd1);
        chk("div4_h200_b", 64'(h_w[1]), 64'd200);
        chk("div4_pe_b", 64'(pe_w[1]), 64'd1);
        tick();
        chk("div4_hold_b", 64'(h_w[1]), 64'd200);
        chk("div4_pe_off_b", 64'(pe_w[1]), 64'd0);
        repeat (3) tick();
        chk("div4_h201_b", 64'(h_w[1]), 64'd201);
        repeat (2396) tick();
        chk("div4_line_b", 64'({h_w[1], v_w[1]}), {44'd0, 10'd0, 10'd1});
        chk("div4_ls_b", 64'(ls_w[1]), 64'd1);

        repeat (300) tick();
        chk("pre_rst_h_a", 64'(h_w[0]), 64'd300);
        rst[0] = 1'b1;
        tick();
        chk("midrst_run_a", 64'(run_w[0]), 64'd0);
        chk("midrst_hv_a", 64'({h_w[0], v_w[0]}), 64'd0);
        tick();
        chk("rst_hold_run_a", 64'(run_w[0]), 64'd0);
        rst[0] = 1'b0;
        tick();
        chk("rst_rel_lat_a", 64'(run_w[0]), 64'd0);
        tick();
        chk("rst_rel_fs_a", 64'(fs_w[0]), 64'd1);

        for (int k = 0; k < 6000; k++) begin
            for (int d = 2; d < ND; d++) begin
                rst[d] = ($urandom_range(0, 799) == 0);
                if ($urandom_range(0, (d == 2) ? 39 : 199) == 0) en[d] = !en[d];
            end
            tick();
        end
        rst[2] = 1'b0;
        rst[3] = 1'b0;
        en[2]  = 1'b1;

        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (run_w[2] && h_w[2] == 10'd2 && v_w[2] == 10'd1) found = 1'b1;
        end
        chk("drain_sync_c", 64'(found), 64'd1);
        en[2] = 1'b0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (!run_w[2]) break;
        end
        chk("drain_len_c", 64'(n), 64'd38);
        chk("drain_hv_c", 64'({h_w[2], v_w[2]}), 64'd0);

        en[2] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (run_w[2] && h_w[2] == 10'd2 && v_w[2] == 10'd1) found = 1'b1;
        end
        chk("reen_sync_c", 64'(found), 64'd1);
        en[2] = 1'b0;
        repeat (5) tick();
        en[2] = 1'b1;
        gap = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!run_w[2]) gap++;
        end
        chk("reen_gap_c", 64'(gap), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
